// File: rtl/spmv_sched_pkg.sv
// rtl/spmv_sched_pkg.sv - shared state type and width defaults for the SpMV row scheduler
package spmv_sched_pkg;

  localparam int ROW_W_DEF     = 32;
  localparam int RES_W_DEF     = 256;
  localparam int ORD_DEPTH_DEF = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FIRST = 2'd1,
    ST_ROWS  = 2'd2,
    ST_DRAIN = 2'd3
  } sched_state_t;

endpackage

// File: rtl/sched_order_fifo.sv
// rtl/sched_order_fifo.sv - 1-bit order FIFO recording empty (0) / non-empty (1) rows in program order
module sched_order_fifo #(
  parameter int DEPTH = 16
) (
  input  logic clk,
  input  logic rstn,
  input  logic push,
  input  logic push_bit,
  input  logic pop,
  output logic head,
  output logic full,
  output logic empty
);

  localparam int          AW       = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [DEPTH-1:0] mem;
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic [AW:0]      count_nxt;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // Occupancy after this cycle's push and pop
  always_comb begin
    count_nxt = count;
    if (do_push && !do_pop) begin
      count_nxt = count + (AW+1)'(1);
    end else if (do_pop && !do_push) begin
      count_nxt = count - (AW+1)'(1);
    end
  end

  // Storage, pointers and registered full/empty flags
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mem    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_bit;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      count <= count_nxt;
      full  <= (count_nxt == FULL_CNT);
      empty <= (count_nxt == '0);
    end
  end

endmodule

// File: rtl/spmv_row_sched.sv
// rtl/spmv_row_sched.sv - CSR row scheduler: issues per-row nnz to the dot lane, emits ordered row results
module spmv_row_sched
  import spmv_sched_pkg::*;
#(
  parameter int ROW_W     = ROW_W_DEF,
  parameter int RES_W     = RES_W_DEF,
  parameter int ORD_DEPTH = ORD_DEPTH_DEF
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start,
  input  logic [ROW_W-1:0] num_rows,
  input  logic [ROW_W-1:0] S_AXIS_PTR_tdata,
  input  logic             S_AXIS_PTR_tvalid,
  output logic             S_AXIS_PTR_tready,
  output logic [ROW_W-1:0] M_AXIS_TIMES_tdata,
  output logic             M_AXIS_TIMES_tvalid,
  input  logic             M_AXIS_TIMES_tready,
  input  logic [RES_W-1:0] S_AXIS_DOT_tdata,
  input  logic             S_AXIS_DOT_tvalid,
  output logic             S_AXIS_DOT_tready,
  output logic [RES_W-1:0] M_AXIS_ROW_tdata,
  output logic [ROW_W-1:0] M_AXIS_ROW_tuser,
  output logic             M_AXIS_ROW_tlast,
  output logic             M_AXIS_ROW_tvalid,
  input  logic             M_AXIS_ROW_tready,
  output logic             busy,
  output logic             done,
  output logic             err
);

  sched_state_t     state;
  logic [ROW_W-1:0] num_rows_q;
  logic [ROW_W-1:0] prev;
  logic [ROW_W-1:0] in_cnt;
  logic [ROW_W-1:0] out_idx;
  logic [ROW_W-1:0] nnz;
  logic             ptr_hs;
  logic             row_hs;
  logic             ord_push;
  logic             ord_bit;
  logic             ord_head;
  logic             ord_full;
  logic             ord_empty;
  logic             last_in;

  assign nnz      = S_AXIS_PTR_tdata - prev;
  assign ptr_hs   = S_AXIS_PTR_tvalid && S_AXIS_PTR_tready;
  assign ord_push = ptr_hs && (state == ST_ROWS);
  // Strictly greater covers both the empty row and the backwards pointer
  assign ord_bit  = (S_AXIS_PTR_tdata > prev);
  assign last_in  = (in_cnt == num_rows_q - ROW_W'(1));
  assign busy     = (state != ST_IDLE);

  // Pointer acceptance: stall on full order FIFO or an occupied TIMES slot
  always_comb begin
    S_AXIS_PTR_tready = 1'b0;
    case (state)
      ST_FIRST: S_AXIS_PTR_tready = 1'b1;
      ST_ROWS:  S_AXIS_PTR_tready = !ord_full && (!M_AXIS_TIMES_tvalid || M_AXIS_TIMES_tready);
      default:  S_AXIS_PTR_tready = 1'b0;
    endcase
  end

  sched_order_fifo #(.DEPTH(ORD_DEPTH)) u_order (
    .clk      (clk),
    .rstn     (rstn),
    .push     (ord_push),
    .push_bit (ord_bit),
    .pop      (row_hs),
    .head     (ord_head),
    .full     (ord_full),
    .empty    (ord_empty)
  );

  // Output side follows the order FIFO head: 0 injects a zero row, 1 forwards the dot result
  assign M_AXIS_ROW_tvalid = !ord_empty && (!ord_head || S_AXIS_DOT_tvalid);
  assign M_AXIS_ROW_tdata  = (!ord_empty && ord_head && S_AXIS_DOT_tvalid) ? S_AXIS_DOT_tdata : '0;
  assign M_AXIS_ROW_tuser  = out_idx;
  assign M_AXIS_ROW_tlast  = M_AXIS_ROW_tvalid && (out_idx == num_rows_q - ROW_W'(1));
  assign S_AXIS_DOT_tready = !ord_empty && ord_head && M_AXIS_ROW_tready;
  assign row_hs            = M_AXIS_ROW_tvalid && M_AXIS_ROW_tready;

  // TIMES output register: loaded by a non-empty row, cleared when taken
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      M_AXIS_TIMES_tvalid <= 1'b0;
      M_AXIS_TIMES_tdata  <= '0;
    end else begin
      if (M_AXIS_TIMES_tvalid && M_AXIS_TIMES_tready) begin
        M_AXIS_TIMES_tvalid <= 1'b0;
      end
      if (ord_push && ord_bit) begin
        M_AXIS_TIMES_tvalid <= 1'b1;
        M_AXIS_TIMES_tdata  <= nnz;
      end
    end
  end

  // Scheduler FSM, row counters and status flags
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= ST_IDLE;
      num_rows_q <= '0;
      prev       <= '0;
      in_cnt     <= '0;
      out_idx    <= '0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      done <= 1'b0;
      if (row_hs) begin
        out_idx <= out_idx + ROW_W'(1);
      end
      case (state)
        ST_IDLE: begin
          if (start) begin
            num_rows_q <= num_rows;
            err        <= 1'b0;
            in_cnt     <= '0;
            out_idx    <= '0;
            state      <= ST_FIRST;
          end
        end
        ST_FIRST: begin
          if (ptr_hs) begin
            prev  <= S_AXIS_PTR_tdata;
            state <= (num_rows_q == '0) ? ST_DRAIN : ST_ROWS;
          end
        end
        ST_ROWS: begin
          if (ptr_hs) begin
            prev   <= S_AXIS_PTR_tdata;
            in_cnt <= in_cnt + ROW_W'(1);
            if (S_AXIS_PTR_tdata < prev) begin
              err <= 1'b1;
            end
            if (last_in) begin
              state <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          if ((row_hs && M_AXIS_ROW_tlast) || (num_rows_q == '0)) begin
            done  <= 1'b1;
            state <= ST_IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spmv_row_sched.sv
// tb/tb_spmv_row_sched.sv - self-checking bench for spmv_row_sched
`timescale 1ns/1ps
module tb_spmv_row_sched;

  localparam int ROW_W     = 32;
  localparam int RES_W     = 256;
  localparam int ORD_DEPTH = 16;

  logic             clk = 1'b0;
  logic             rstn = 1'b0;
  logic             start = 1'b0;
  logic [ROW_W-1:0] num_rows = '0;
  logic [ROW_W-1:0] S_AXIS_PTR_tdata = '0;
  logic             S_AXIS_PTR_tvalid = 1'b0;
  logic             S_AXIS_PTR_tready;
  logic [ROW_W-1:0] M_AXIS_TIMES_tdata;
  logic             M_AXIS_TIMES_tvalid;
  logic             M_AXIS_TIMES_tready = 1'b0;
  logic [RES_W-1:0] S_AXIS_DOT_tdata = '0;
  logic             S_AXIS_DOT_tvalid = 1'b0;
  logic             S_AXIS_DOT_tready;
  logic [RES_W-1:0] M_AXIS_ROW_tdata;
  logic [ROW_W-1:0] M_AXIS_ROW_tuser;
  logic             M_AXIS_ROW_tlast;
  logic             M_AXIS_ROW_tvalid;
  logic             M_AXIS_ROW_tready = 1'b0;
  logic             busy;
  logic             done;
  logic             err;

  always #5 clk = ~clk;

  spmv_row_sched #(.ROW_W(ROW_W), .RES_W(RES_W), .ORD_DEPTH(ORD_DEPTH)) dut (
    .clk                 (clk),
    .rstn                (rstn),
    .start               (start),
    .num_rows            (num_rows),
    .S_AXIS_PTR_tdata    (S_AXIS_PTR_tdata),
    .S_AXIS_PTR_tvalid   (S_AXIS_PTR_tvalid),
    .S_AXIS_PTR_tready   (S_AXIS_PTR_tready),
    .M_AXIS_TIMES_tdata  (M_AXIS_TIMES_tdata),
    .M_AXIS_TIMES_tvalid (M_AXIS_TIMES_tvalid),
    .M_AXIS_TIMES_tready (M_AXIS_TIMES_tready),
    .S_AXIS_DOT_tdata    (S_AXIS_DOT_tdata),
    .S_AXIS_DOT_tvalid   (S_AXIS_DOT_tvalid),
    .S_AXIS_DOT_tready   (S_AXIS_DOT_tready),
    .M_AXIS_ROW_tdata    (M_AXIS_ROW_tdata),
    .M_AXIS_ROW_tuser    (M_AXIS_ROW_tuser),
    .M_AXIS_ROW_tlast    (M_AXIS_ROW_tlast),
    .M_AXIS_ROW_tvalid   (M_AXIS_ROW_tvalid),
    .M_AXIS_ROW_tready   (M_AXIS_ROW_tready),
    .busy                (busy),
    .done                (done),
    .err                 (err)
  );

  typedef struct {
    logic [RES_W-1:0] data;
    logic [ROW_W-1:0] idx;
    logic             last;
  } row_t;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // expected behaviour and observations
  row_t             exp_row[$];
  logic [ROW_W-1:0] exp_times[$];
  logic             exp_err;
  int               cur_n;
  logic [ROW_W-1:0] got_times[$];
  row_t             got_row[$];
  logic [ROW_W-1:0] lit[$];
  int last_row_cyc, last_ptr_cyc, done_cnt, ptr_hs_cnt, row_hs_cnt, max_inflight;
  logic stall_seen;

  // stimulus state
  logic [ROW_W-1:0] tv[$];
  logic [ROW_W-1:0] ptr_q[$];
  int dot_pend[$];
  int dot_k;
  int dot_delay;
  logic times_mode, row_mode;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [RES_W-1:0] act, input logic [RES_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [RES_W-1:0] dot_val(input int k);
    logic [31:0] w;
    w = 32'hD0700000 + 32'(k);
    return {8{w}};
  endfunction

  // Model: row i spans ptr[i]..ptr[i+1]; non-empty rows consume dot results in order
  function automatic void build_model(input int n, input logic [ROW_W-1:0] p[$]);
    int k;
    row_t r;
    exp_row.delete();
    exp_times.delete();
    exp_err = 1'b0;
    k = 0;
    for (int i = 0; i < n; i++) begin
      r.idx  = ROW_W'(i);
      r.last = (i == n - 1);
      if (p[i+1] > p[i]) begin
        exp_times.push_back(p[i+1] - p[i]);
        r.data = dot_val(k);
        k++;
      end else begin
        r.data = '0;
        if (p[i+1] < p[i]) exp_err = 1'b1;
      end
      exp_row.push_back(r);
    end
  endfunction

  // Compare process: every handshake and every done pulse is checked against the model
  always @(negedge clk) begin
    int inflight;
    row_t e;
    if (rstn) begin
      inflight = ((ptr_hs_cnt > 0) ? ptr_hs_cnt - 1 : 0) - row_hs_cnt;
      if (inflight > max_inflight) max_inflight = inflight;
      if (inflight >= ORD_DEPTH && S_AXIS_PTR_tvalid && !S_AXIS_PTR_tready) stall_seen = 1'b1;
      if (M_AXIS_TIMES_tvalid && M_AXIS_TIMES_tready) begin
        got_times.push_back(M_AXIS_TIMES_tdata);
        if (exp_times.size() == 0) check("times_unexpected", RES_W'(M_AXIS_TIMES_tdata), '1);
        else check("times", RES_W'(M_AXIS_TIMES_tdata), RES_W'(exp_times.pop_front()));
      end
      if (M_AXIS_ROW_tvalid && M_AXIS_ROW_tready) begin
        e.data = M_AXIS_ROW_tdata;
        e.idx  = M_AXIS_ROW_tuser;
        e.last = M_AXIS_ROW_tlast;
        got_row.push_back(e);
        row_hs_cnt++;
        last_row_cyc = cyc;
        if (exp_row.size() == 0) begin
          check("row_unexpected", RES_W'(M_AXIS_ROW_tuser), '1);
        end else begin
          e = exp_row.pop_front();
          check("row_data", M_AXIS_ROW_tdata, e.data);
          check("row_tuser", RES_W'(M_AXIS_ROW_tuser), RES_W'(e.idx));
          check("row_tlast", RES_W'(M_AXIS_ROW_tlast), RES_W'(e.last));
        end
      end
      if (S_AXIS_PTR_tvalid && S_AXIS_PTR_tready) begin
        ptr_hs_cnt++;
        last_ptr_cyc = cyc;
      end
      if (done) begin
        done_cnt++;
        check("done_latency", RES_W'(cyc), RES_W'((cur_n == 0) ? last_ptr_cyc + 2 : last_row_cyc + 1));
        check("busy_at_done", RES_W'(busy), '0);
      end
    end
  end

  task automatic drive();
    S_AXIS_PTR_tvalid   = (ptr_q.size() > 0);
    S_AXIS_PTR_tdata    = (ptr_q.size() > 0) ? ptr_q[0] : '0;
    M_AXIS_TIMES_tready = times_mode ? cyc[0] : 1'b1;
    M_AXIS_ROW_tready   = row_mode ? ((cyc % 3) != 0) : 1'b1;
    S_AXIS_DOT_tvalid   = (dot_pend.size() > 0) && (dot_pend[0] <= cyc);
    S_AXIS_DOT_tdata    = S_AXIS_DOT_tvalid ? dot_val(dot_k) : '0;
  endtask

  // One clock of the pointer source and dot-lane model
  task automatic cycle();
    logic ptr_taken, times_taken, dot_taken;
    @(negedge clk);
    ptr_taken   = S_AXIS_PTR_tvalid && S_AXIS_PTR_tready;
    times_taken = M_AXIS_TIMES_tvalid && M_AXIS_TIMES_tready;
    dot_taken   = S_AXIS_DOT_tvalid && S_AXIS_DOT_tready;
    @(posedge clk);
    #1;
    if (ptr_taken) void'(ptr_q.pop_front());
    if (dot_taken) begin
      void'(dot_pend.pop_front());
      dot_k++;
    end
    if (times_taken) dot_pend.push_back(cyc + dot_delay);
    drive();
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_ptr_tready"}, RES_W'(S_AXIS_PTR_tready), '0);
    check({tag, "_times_tvalid"}, RES_W'(M_AXIS_TIMES_tvalid), '0);
    check({tag, "_times_tdata"}, RES_W'(M_AXIS_TIMES_tdata), '0);
    check({tag, "_dot_tready"}, RES_W'(S_AXIS_DOT_tready), '0);
    check({tag, "_row_tvalid"}, RES_W'(M_AXIS_ROW_tvalid), '0);
    check({tag, "_row_tdata"}, M_AXIS_ROW_tdata, '0);
    check({tag, "_row_tuser"}, RES_W'(M_AXIS_ROW_tuser), '0);
    check({tag, "_row_tlast"}, RES_W'(M_AXIS_ROW_tlast), '0);
    check({tag, "_busy_done_err"}, RES_W'({busy, done, err}), '0);
  endtask

  task automatic start_test(input int n);
    cur_n = n;
    build_model(n, tv);
    ptr_q = tv;
    dot_pend.delete();
    dot_k = 0;
    got_times.delete();
    got_row.delete();
    done_cnt = 0; ptr_hs_cnt = 0; row_hs_cnt = 0; max_inflight = 0; stall_seen = 1'b0;
    drive();
    start    = 1'b1;
    num_rows = ROW_W'(n);
    cycle();
    start = 1'b0;
    check("err_clear_on_start", RES_W'(err), '0);
    check("busy_after_start", RES_W'(busy), RES_W'(1));
  endtask

  task automatic finish_test(input string name, input int budget);
    for (int i = 0; i < budget && done_cnt == 0; i++) cycle();
    if (done_cnt == 0) begin
      errors++;
      $display("FAIL %s_timeout: got no done within %0d cycles", name, budget);
    end
    repeat (3) cycle();
    check({name, "_done_once"}, RES_W'(done_cnt), RES_W'(1));
    check({name, "_rows_left"}, RES_W'(exp_row.size()), '0);
    check({name, "_times_left"}, RES_W'(exp_times.size()), '0);
    check({name, "_err"}, RES_W'(err), RES_W'(exp_err));
  endtask

  task automatic check_lit_times(input string name);
    check({name, "_times_count"}, RES_W'(got_times.size()), RES_W'(lit.size()));
    for (int i = 0; i < lit.size() && i < got_times.size(); i++)
      check({name, "_times_lit"}, RES_W'(got_times[i]), RES_W'(lit[i]));
  endtask

  initial begin
    times_mode = 1'b0; row_mode = 1'b0; dot_delay = 2;
    drive();
    repeat (2) @(posedge clk);
    #1;
    check_reset_vals("reset");
    rstn = 1'b1;
    cycle();

    // 3 rows, pointers 0,2,5,6, TIMES back-pressured every other cycle
    times_mode = 1'b1;
    tv = '{32'd0, 32'd2, 32'd5, 32'd6};
    start_test(3);
    finish_test("t1", 300);
    lit = '{32'd2, 32'd3, 32'd1};
    check_lit_times("t1");
    check("t1_row2_data", got_row[2].data, dot_val(2));
    check("t1_row2_last", RES_W'(got_row[2].last), RES_W'(1));
    times_mode = 1'b0;

    // empty rows interleaved, ROW back-pressured
    row_mode = 1'b1;
    tv = '{32'd0, 32'd0, 32'd3, 32'd3, 32'd4};
    start_test(4);
    finish_test("t2", 300);
    lit = '{32'd3, 32'd1};
    check_lit_times("t2");
    check("t2_row0_zero", got_row[0].data, '0);
    check("t2_row1_data", got_row[1].data, dot_val(0));
    check("t2_row2_zero", got_row[2].data, '0);
    check("t2_row3_idx", RES_W'(got_row[3].idx), RES_W'(3));
    row_mode = 1'b0;

    // zero-row matrix
    tv = '{32'd7};
    start_test(0);
    finish_test("t3", 100);
    check("t3_no_times", RES_W'(got_times.size()), '0);
    check("t3_no_rows", RES_W'(got_row.size()), '0);

    // backwards pointer sets sticky err
    tv = '{32'd0, 32'd5, 32'd2, 32'd4};
    start_test(3);
    finish_test("t4", 300);
    lit = '{32'd5, 32'd2};
    check_lit_times("t4");
    check("t4_row1_zero", got_row[1].data, '0);
    repeat (5) cycle();
    check("t4_err_held", RES_W'(err), RES_W'(1));

    // 40 rows, long dot latency, ROW tready toggling: FIFO fills and throttles pointers
    dot_delay = 50;
    row_mode  = 1'b1;
    tv.delete();
    for (int i = 0; i <= 40; i++) tv.push_back(ROW_W'(i));
    start_test(40);
    finish_test("t5", 3000);
    check("t5_max_inflight", RES_W'(max_inflight), RES_W'(ORD_DEPTH));
    check("t5_ptr_stall", RES_W'(stall_seen), RES_W'(1));
    check("t5_row_count", RES_W'(got_row.size()), RES_W'(40));
    row_mode  = 1'b0;
    dot_delay = 3;

    // reset mid-matrix at row 10, then a fresh 2-row matrix
    start_test(40);
    for (int i = 0; i < 500 && ptr_hs_cnt < 11; i++) cycle();
    check("t6_reached_row10", RES_W'(ptr_hs_cnt >= 11), RES_W'(1));
    rstn = 1'b0;
    ptr_q.delete();
    dot_pend.delete();
    exp_row.delete();
    exp_times.delete();
    drive();
    #1;
    check_reset_vals("midreset");
    @(posedge clk);
    #1;
    rstn = 1'b1;
    cycle();
    tv = '{32'd10, 32'd13, 32'd13};
    start_test(2);
    finish_test("t6", 300);
    lit = '{32'd3};
    check_lit_times("t6");
    check("t6_row0_data", got_row[0].data, dot_val(0));
    check("t6_row1_zero", got_row[1].data, '0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/spmv_row_sched.md
# spmv_row_sched

Row scheduler for the SpMV dot-product lane. Consumes the CSR row-pointer stream for one matrix, derives each row's non-zero count, issues it as the TIMES word to the dot-product datapath, and emits one ordered result per row tagged with its row index. Empty rows (nnz = 0) never reach the datapath, which cannot close an accumulation without a product; the scheduler injects a zero result for them in program order.

## Interface
- `ROW_W`, 32, width of row pointers, row counts and row index
- `RES_W`, 256, width of the fixed-point dot result
- `ORD_DEPTH`, 16, order-FIFO depth (power of 2); caps rows in flight
- `clk`  in  1  single clock
- `rstn`  in  1  reset, asynchronous, active-low
- `start`  in  1  one-cycle pulse; latches `num_rows`; ignored while `busy`
- `num_rows`  in  ROW_W  rows in this matrix
- `S_AXIS_PTR_tdata / tvalid / tready`  in/in/out  ROW_W  row pointers, exactly `num_rows`+1 words
- `M_AXIS_TIMES_tdata / tvalid / tready`  out/out/in  ROW_W  nnz per non-empty row, to the dot lane
- `S_AXIS_DOT_tdata / tvalid / tready`  in/in/out  RES_W  accumulated results from the dot lane
- `M_AXIS_ROW_tdata / tuser / tlast / tvalid / tready`  out  RES_W/ROW_W/1/1 (tready in)  ordered row results; `tuser` = row index; `tlast` on row `num_rows`-1
- `busy`  out  1  high from accepted `start` until `done`
- `done`  out  1  one-cycle pulse after the last row result is accepted
- `err`  out  1  sticky: a pointer was less than its predecessor; cleared by next `start`

## Operation
- FSM IDLE -> FIRST -> ROWS -> DRAIN -> IDLE.
- IDLE: `start` latches `num_rows`, clears `err`, row counters and output index; -> FIRST.
- FIRST: accept one pointer into `prev`; -> ROWS, or -> DRAIN if `num_rows` = 0.
- ROWS: accept a pointer `cur` only when order FIFO not full and the TIMES output register is empty or being taken this cycle. nnz = `cur` - `prev` (ROW_W, unsigned). nnz > 0: load TIMES register, push order bit 1. nnz = 0 or `cur` < `prev`: push order bit 0, no TIMES; `cur` < `prev` also sets `err`. `prev` <= `cur`. After the `num_rows`-th row -> DRAIN.
- DRAIN: wait for order FIFO empty and last output accepted; pulse `done`; -> IDLE.
- Output side, independent of the FSM: order FIFO head 0 -> present `tdata` = 0; head 1 -> present `S_AXIS_DOT_tdata` when `S_AXIS_DOT_tvalid`. `S_AXIS_DOT_tready` = head valid & head = 1 & `M_AXIS_ROW_tready`. Pop on ROW handshake; output index increments per pop.
- `S_AXIS_PTR_tready` low in IDLE and DRAIN.
- Dot results arriving with order head 0 or FIFO empty are held off (tready low), never dropped.
- `rstn` low mid-operation: FSM to IDLE, FIFO emptied, all valids low; the dot lane must be reset concurrently because in-flight results are not tracked across reset.

## Timing
- Reset values: all tvalid/tready 0, `busy` 0, `done` 0, `err` 0, `tlast` 0, data outputs 0.
- Pointer accept -> `M_AXIS_TIMES_tvalid` next cycle (registered).
- Pointer accept -> order entry visible at FIFO head next cycle; empty row reaches `M_AXIS_ROW_tvalid` next cycle at the earliest.
- Sustained throughput: one pointer per cycle when TIMES and ROW are not back-pressured.
- Simultaneous push and pop on a full FIFO: pop takes effect, push stalls (tready computed from registered full).
- `done` asserted the cycle after the final ROW handshake; `busy` falls in the same cycle.

## Structure
- Shared package `spmv_sched_pkg`: FSM state enum, `ROW_W`/`RES_W` defaults.
- One sub-module: `sched_order_fifo`, 1-bit-wide synchronous FIFO, depth `ORD_DEPTH`, registered full/empty, async active-low reset.

## Test plan
- `num_rows`=3, pointers 0,2,5,6; dot returns A,B,C -> TIMES 2,3,1; ROW (A,0),(B,1),(C,2,tlast); `done` once.
- `num_rows`=4, pointers 0,0,3,3,4; dot returns A,B -> TIMES 3,1; ROW (0,0),(A,1),(0,2),(B,3,tlast).
- `num_rows`=0, one pointer 7 -> no TIMES, no ROW, `done` 2 cycles after the pointer handshake.
- Pointers 0,5,2,4 (`num_rows`=3) -> TIMES 5,2; row 1 emits zero; `err` set and held until next `start`.
- `num_rows`=40, all nnz=1, dot result delayed 50 cycles, ROW tready toggling -> at most `ORD_DEPTH` rows in flight, PTR tready drops when full, 40 results in index order, no loss.
- Reset asserted at row 10 of 40 -> all outputs return to reset values; a new `start` runs a 2-row matrix correctly.
